// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory controller slice: default bus widths
// and the controller state encoding.
// Optional feature macro used by this slice: MEM_CTRL_VERIFY_EN
// (write followed by read-back compare of the same address).
package mem_ctrl_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_SETUP   = 3'd1,
    ST_W_STROBE  = 3'd2,
    ST_W_HOLD    = 3'd3,
    ST_R_SETUP   = 3'd4,
    ST_R_STROBE  = 3'd5,
    ST_R_CAPTURE = 3'd6,
    ST_RESP      = 3'd7
  } mem_ctrl_state_t;

  // True in the three write-phase states, i.e. whenever the controller owns
  // the shared data bus.
  function automatic logic drives_bus(input mem_ctrl_state_t s);
    return (s == ST_W_SETUP) || (s == ST_W_STROBE) || (s == ST_W_HOLD);
  endfunction

endpackage

// File: rtl/mem_ctrl_bus_if.sv
// mem_ctrl_bus_if
// Data-side attachment to the shared memory bus.
//   clk, rst  : clock, asynchronous active-high reset
//   oe        : drive the bus with wdata (else high-Z)
//   wdata     : write data / expected data for read-back compare
//   clear     : zero the capture and error registers (new request accepted)
//   capture   : sample the bus into rdata at the end of this cycle
//   check_en  : when capturing, also compare the bus against wdata
//   rdata     : captured read data
//   err       : captured compare mismatch
//   mem_data  : shared tristate data bus
module mem_ctrl_bus_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  input  logic              capture,
  input  logic              check_en,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  inout  wire  [DATA_W-1:0] mem_data
);

  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  // Bus is released whenever oe is low; oe is decoded straight from the
  // state register so an asynchronous reset releases it immediately.
  assign mem_data = oe ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (clear) begin
      // A write without read-back must respond with zero data.
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (capture) begin
      rdata_reg <= mem_data;
      err_reg   <= check_en && (mem_data != wdata);
    end
  end

  assign rdata = rdata_reg;
  assign err   = err_reg;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl
// Single-word request/response controller for a 64x64 asynchronous memory
// with level-sensitive strobes and a shared tristate data bus.
// Build option: MEM_CTRL_VERIFY_EN -- every write is followed by a read of
// the same address; the response carries the read-back data and a mismatch
// flag. Without it, writes respond with zero data and rsp_err stays 0.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only when idle)
//   req_wr/addr/wdata     : request command, address, write data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : response data and verify mismatch flag
//   mem_wr, mem_rd        : memory strobes, active high
//   mem_addr              : memory address
//   mem_data              : shared tristate data bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  mem_ctrl_state_t   state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              accept;
  logic              check_en;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address and data are latched only at accept, so mem_addr changes on
  // entry to the first SETUP state and holds until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
    end
  end

`ifdef MEM_CTRL_VERIFY_EN
  // Remembers whether the current read phase is a write read-back, so a
  // plain read never reports a mismatch.
  logic wr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_reg <= 1'b0;
    end else if (accept) begin
      wr_reg <= req_wr;
    end
  end

  assign check_en = wr_reg;
`else
  assign check_en = 1'b0;
`endif

  // --------------------------------------------------- next state / outputs
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = req_wr ? ST_W_SETUP : ST_R_SETUP;
        end
      end

      ST_W_SETUP: begin
        state_next = ST_W_STROBE;
      end

      ST_W_STROBE: begin
        mem_wr     = 1'b1;
        state_next = ST_W_HOLD;
      end

      ST_W_HOLD: begin
`ifdef MEM_CTRL_VERIFY_EN
        state_next = ST_R_SETUP;
`else
        state_next = ST_RESP;
`endif
      end

      ST_R_SETUP: begin
        state_next = ST_R_STROBE;
      end

      ST_R_STROBE: begin
        mem_rd     = 1'b1;
        state_next = ST_R_CAPTURE;
      end

      // Strobe stays high through the capture cycle so the data is settled
      // when it is registered at the end of this cycle.
      ST_R_CAPTURE: begin
        mem_rd     = 1'b1;
        state_next = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_addr = addr_reg;

  // ------------------------------------------------------------ data side
  mem_ctrl_bus_if #(
    .DATA_W (DATA_W)
  ) u_bus (
    .clk      (clk),
    .rst      (rst),
    .oe       (drives_bus(state_reg)),
    .wdata    (wdata_reg),
    .clear    (accept),
    .capture  (state_reg == ST_R_CAPTURE),
    .check_en (check_en),
    .rdata    (rsp_rdata),
    .err      (rsp_err),
    .mem_data (mem_data)
  );

endmodule
